// File: rtl/exec_wb_pkg.sv
// rtl/exec_wb_pkg.sv - op_sel encodings and divide-by-zero result constants
package exec_wb_pkg;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MFHI = 3'd3,
        OP_MFLO = 3'd4,
        OP_LOAD = 3'd5,
        OP_LINK = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    // Divide by zero: every quotient bit takes this value; hi returns the dividend.
    localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 iterative multiplier/divider, one bit per cycle
module muldiv_iter
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              div,
    input  logic              signed_md,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]    cnt;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic                b_zero;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   nxt_hi;
    logic [DATA_W-1:0]   nxt_lo;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W-1:0] prod;

    // Iterate on magnitudes; signs are reapplied on the final step.
    assign a_mag = (signed_md && a[DATA_W-1]) ? -a : a;
    assign b_mag = (signed_md && b[DATA_W-1]) ? -b : b;
    assign done  = busy && (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        trial   = shifted - {1'b0, opnd};
        if (is_div) begin
            if (!trial[DATA_W]) begin
                nxt_hi = trial[DATA_W-1:0];
                nxt_lo = {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[DATA_W-1:0];
                nxt_lo = {acc_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[DATA_W:1];
            nxt_lo = {sum[0], acc_lo[DATA_W-1:1]};
        end
        prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        if (is_div) begin
            hi = neg_r ? -nxt_hi : nxt_hi;
            lo = b_zero ? {DATA_W{DIV0_LO_BIT}} : (neg_q ? -nxt_lo : nxt_lo);
        end else begin
            hi = prod[2*DATA_W-1:DATA_W];
            lo = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= div;
            neg_q  <= signed_md && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_r  <= signed_md && a[DATA_W-1];
            b_zero <= (b == '0);
            opnd   <= div ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= div ? a_mag : b_mag;
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_wb_stage.sv
// rtl/exec_wb_stage.sv - execute/write-back stage with forwarding and muldiv interlock
module exec_wb_stage
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic              md_signed,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              reg_we,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PC_W-1:0]   link_pc,
    output logic [DATA_W-1:0] opa_fwd,
    output logic [DATA_W-1:0] opb_fwd,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              md_busy
);

    op_e               op;
    logic              md_op;
    logic              hilo_op;
    logic              wb_op;
    logic              accept;
    logic              md_done;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] wb_src;

    assign op      = op_e'(op_sel);
    assign md_op   = (op == OP_MULT) || (op == OP_DIV);
    assign hilo_op = (op == OP_MFHI) || (op == OP_MFLO);
    assign wb_op   = (op == OP_ALU) || (op == OP_LOAD) || (op == OP_LINK) || hilo_op;

    // Only ops that start or read the muldiv unit wait; everything else flows past it.
    assign in_ready = !(md_busy && (md_op || hilo_op));
    assign accept   = in_valid && in_ready;

    assign opa_fwd = (wb_we && (wb_addr == rs_addr)) ? wb_data : rs_data;
    assign opb_fwd = (wb_we && (wb_addr == rt_addr)) ? wb_data : rt_data;

    muldiv_iter #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && md_op),
        .div       (op == OP_DIV),
        .signed_md (md_signed),
        .a         (opa_fwd),
        .b         (opb_fwd),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        wb_src = alu_result;
        case (op)
            OP_LOAD: wb_src = mem_rdata;
            OP_LINK: wb_src = DATA_W'(link_pc);
            OP_MFHI: wb_src = hi;
            OP_MFLO: wb_src = lo;
            default: wb_src = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= md_hi;
            lo <= md_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= 1'b0;
            if (accept && wb_op) begin
                wb_we   <= reg_we && (dest_addr != '0);
                wb_addr <= dest_addr;
                wb_data <= wb_src;
            end
        end
    end

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb/tb_exec_wb_stage.sv - randomized and directed bench for exec_wb_stage against a reference model
module tb_exec_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PC_W   = 10;

    localparam logic [2:0] T_ALU  = 3'd0;
    localparam logic [2:0] T_MULT = 3'd1;
    localparam logic [2:0] T_DIV  = 3'd2;
    localparam logic [2:0] T_MFHI = 3'd3;
    localparam logic [2:0] T_MFLO = 3'd4;
    localparam logic [2:0] T_LOAD = 3'd5;
    localparam logic [2:0] T_LINK = 3'd6;
    localparam logic [2:0] T_NOP  = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_sel;
    logic              md_signed;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] dest_addr;
    logic              reg_we;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [PC_W-1:0]   link_pc;
    logic [DATA_W-1:0] opa_fwd;
    logic [DATA_W-1:0] opb_fwd;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              md_busy;

    always #5 clk = ~clk;

    exec_wb_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .PC_W  (PC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .md_signed (md_signed),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .dest_addr (dest_addr),
        .reg_we    (reg_we),
        .alu_result(alu_result),
        .mem_rdata (mem_rdata),
        .link_pc   (link_pc),
        .opa_fwd   (opa_fwd),
        .opb_fwd   (opb_fwd),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .md_busy   (md_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_rhi;
    logic [31:0] m_rlo;
    int          m_left;
    logic        last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] md_ref(input logic is_div, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = sgn ? longint'(signed'(a)) : longint'(a);
        sb = sgn ? longint'(signed'(b)) : longint'(b);
        if (!is_div) begin
            r = sa * sb;
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'd0, 32'h8000_0000};
        end else begin
            q  = sa / sb;
            rm = sa % sb;
            r  = {rm[31:0], q[31:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        logic        rdy;
        logic [31:0] fa, fb;
        logic [63:0] res;
        #2;
        rdy = !((m_left > 0) && (op_sel inside {T_MULT, T_DIV, T_MFHI, T_MFLO}));
        fa  = (m_we && m_addr == rs_addr) ? m_data : rs_data;
        fb  = (m_we && m_addr == rt_addr) ? m_data : rt_data;
        check("in_ready", in_ready, rdy);
        check("opa_fwd", opa_fwd, fa);
        check("opb_fwd", opb_fwd, fb);
        last_acc = in_valid && rdy;
        @(posedge clk);
        if (!rst) begin
            m_we = 0; m_addr = 0; m_data = 0; m_hi = 0; m_lo = 0; m_left = 0;
            last_acc = 0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_rhi;
                    m_lo = m_rlo;
                end
            end
            m_we = 0;
            if (last_acc) begin
                case (op_sel)
                    T_MULT, T_DIV: begin
                        res    = md_ref(op_sel == T_DIV, md_signed, fa, fb);
                        m_rhi  = res[63:32];
                        m_rlo  = res[31:0];
                        m_left = DATA_W;
                    end
                    T_NOP: ;
                    default: begin
                        m_we   = reg_we && (dest_addr != 0);
                        m_addr = dest_addr;
                        case (op_sel)
                            T_LOAD:  m_data = mem_rdata;
                            T_LINK:  m_data = {22'd0, link_pc};
                            T_MFHI:  m_data = m_hi;
                            T_MFLO:  m_data = m_lo;
                            default: m_data = alu_result;
                        endcase
                    end
                endcase
            end
        end
        #1;
        check("wb_we", wb_we, m_we);
        check("wb_addr", wb_addr, m_addr);
        check("wb_data", wb_data, m_data);
        check("md_busy", md_busy, m_left > 0);
    endtask

    task automatic drive(input logic [2:0] op, input logic sgn,
                         input logic [4:0] ra, input logic [31:0] da,
                         input logic [4:0] rb, input logic [31:0] db,
                         input logic [4:0] dst, input logic we, input logic [31:0] res);
        in_valid = 1; op_sel = op; md_signed = sgn;
        rs_addr = ra; rs_data = da; rt_addr = rb; rt_data = db;
        dest_addr = dst; reg_we = we;
        alu_result = res; mem_rdata = ~res; link_pc = res[9:0];
    endtask

    task automatic idle();
        in_valid = 0; op_sel = T_NOP; reg_we = 0;
    endtask

    // Present op_sel until accepted (bounded); returns stall count.
    task automatic wait_accept(input int limit, output int stalls);
        logic got;
        stalls = 0;
        got = 0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            if (last_acc) got = 1;
            else stalls++;
        end
        check("accept_within_bound", got, 1);
    endtask

    task automatic md_case(input string tag, input logic is_div, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls;
        drive(is_div ? T_DIV : T_MULT, sgn, 5'd20, a, 5'd21, b, 5'd0, 1'b0, 32'd0);
        tick();
        check({tag, "_start"}, last_acc, 1);
        drive(T_MFLO, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 1'b1, 32'd0);
        wait_accept(40, stalls);
        check({tag, "_stall"}, 64'(stalls), 64'd32);
        check({tag, "_lo"}, wb_data, exp_lo);
        drive(T_MFHI, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd8, 1'b1, 32'd0);
        tick();
        check({tag, "_hi"}, wb_data, exp_hi);
        idle();
    endtask

    initial begin
        int stalls;
        m_we = 0; m_addr = 0; m_data = 0; m_hi = 0; m_lo = 0;
        m_rhi = 0; m_rlo = 0; m_left = 0; last_acc = 0;
        rst = 0;
        idle();
        md_signed = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
        dest_addr = 0; alu_result = 0; mem_rdata = 0; link_pc = 0;
        @(posedge clk);
        #1;
        tick();
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_md_busy", md_busy, 0);
        rst = 1;

        // ALU write then forwarded read of the same register
        drive(T_ALU, 0, 5'd1, 32'd0, 5'd2, 32'd0, 5'd5, 1'b1, 32'h1234);
        tick();
        check("d036_wb_data", wb_data, 32'h1234);
        drive(T_ALU, 0, 5'd5, 32'd0, 5'd2, 32'd9, 5'd6, 1'b1, 32'h1);
        #1;
        check("d036_opa_fwd", opa_fwd, 32'h1234);
        tick();

        md_case("d037_mult", 0, 1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        md_case("d038_div0", 1, 0, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        md_case("d038_sdiv", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_case("d027_minneg", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        md_case("d_umult", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Writes to register 0 are dropped and never forwarded
        drive(T_ALU, 0, 5'd1, 32'd0, 5'd2, 32'd0, 5'd0, 1'b1, 32'h55);
        tick();
        check("d039_wb_we", wb_we, 0);
        drive(T_ALU, 0, 5'd0, 32'hABCD, 5'd0, 32'h1, 5'd3, 1'b1, 32'h2);
        #1;
        check("d039_opa_fwd", opa_fwd, 32'hABCD);
        tick();

        // ALU ops flow while the multiplier runs; MFHI waits for it
        drive(T_MULT, 0, 5'd20, 32'h0001_0000, 5'd21, 32'h0001_0000, 5'd0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(T_ALU, 0, 5'd1, 32'(i), 5'd2, 32'(i), 5'(10 + i), 1'b1, 32'hA000 + 32'(i));
            tick();
            check("d040_alu_acc", last_acc, 1);
            check("d040_alu_wb", wb_data, 32'hA000 + 32'(i));
        end
        drive(T_MFHI, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b1, 32'd0);
        wait_accept(40, stalls);
        check("d040_mfhi_stall", 64'(stalls), 64'd27);
        check("d040_mfhi_wb", wb_data, 32'd1);

        // Reset in the middle of a divide
        drive(T_DIV, 0, 5'd20, 32'd100, 5'd21, 32'd7, 5'd0, 1'b0, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 9; i++) tick();
        rst = 0;
        tick();
        check("d041_busy", md_busy, 0);
        rst = 1;
        drive(T_MFHI, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b1, 32'd0);
        #1;
        check("d041_ready", in_ready, 1);
        tick();
        check("d041_mfhi", wb_data, 32'd0);
        check("d041_mfhi_we", wb_we, 1);
        drive(T_MFLO, 0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 1'b1, 32'd0);
        tick();
        check("d041_mflo", wb_data, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 599) != 0);
            in_valid   = ($urandom_range(0, 9) < 8);
            op_sel     = 3'($urandom_range(0, 7));
            md_signed  = 1'($urandom_range(0, 1));
            rs_addr    = 5'($urandom_range(0, 3));
            rt_addr    = 5'($urandom_range(0, 3));
            dest_addr  = 5'($urandom_range(0, 3));
            reg_we     = ($urandom_range(0, 3) != 0);
            rs_data    = rnd_word();
            rt_data    = rnd_word();
            alu_result = $urandom;
            mem_rdata  = $urandom;
            link_pc    = 10'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, sets the datapath and register word width.
REQ-002 Parameter ADDR_W, default 5, sets the register-file address width.
REQ-003 Parameter PC_W, default 10, sets the link-address width, zero-extended into wb_data.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  decoded instruction presented this cycle.
REQ-007 in_ready  out  1  stage accepts the instruction; transfer occurs when in_valid&&in_ready.
REQ-008 op_sel  in  3  0 ALU, 1 MULT, 2 DIV, 3 MFHI, 4 MFLO, 5 LOAD, 6 LINK, 7 NOP.
REQ-009 md_signed  in  1  MULT/DIV operands treated as two's complement.
REQ-010 rs_addr, rt_addr  in  ADDR_W  source register numbers.
REQ-011 rs_data, rt_data  in  DATA_W  raw register-file read data.
REQ-012 dest_addr  in  ADDR_W  destination register number.
REQ-013 reg_we  in  1  instruction writes dest_addr.
REQ-014 alu_result, mem_rdata  in  DATA_W  ALU output and data-memory read data.
REQ-015 link_pc  in  PC_W  return address for LINK.
REQ-016 opa_fwd, opb_fwd  out  DATA_W  forwarded rs/rt operands.
REQ-017 wb_we, wb_addr, wb_data  out  1/ADDR_W/DATA_W  registered write-back port.
REQ-018 md_busy  out  1  iterative multiply/divide in progress.

Function
REQ-019 ALU/LOAD/LINK/MFHI/MFLO: wb_* update on the edge that accepts the instruction; wb_data = alu_result / mem_rdata / zero-extended link_pc / hi / lo respectively.
REQ-020 wb_we = reg_we && dest_addr!=0 on accept; 0 on any cycle with no accepted write, and always 0 for MULT, DIV, NOP.
REQ-021 opa_fwd = wb_data when wb_we && wb_addr==rs_addr, else rs_data; opb_fwd likewise with rt_addr.
REQ-022 MULT/DIV capture opa_fwd/opb_fwd on accept; md_busy rises next cycle and stays high exactly DATA_W cycles.
REQ-023 Multiplier and divider are radix-2, one bit per cycle; hi/lo update on the edge where md_busy falls.
REQ-024 MULT: {hi,lo} = full 2*DATA_W product, signed when md_signed.
REQ-025 DIV: lo = quotient, hi = remainder; signed mode truncates toward zero, remainder takes the dividend's sign.
REQ-026 DIV by zero: lo = all ones, hi = dividend; no exception.
REQ-027 Signed most-negative / -1: lo = most-negative value, hi = 0.
REQ-028 in_ready = 0 while md_busy and op_sel in {MULT, DIV, MFHI, MFLO}; otherwise 1.
REQ-029 Other ops proceed during md_busy, with normal write-back and forwarding.
REQ-030 MFHI/MFLO presented on the cycle md_busy falls stall that cycle and are accepted the following cycle with new hi/lo.
REQ-031 in_valid=0 or op_sel=NOP: no state change except muldiv progress; wb_we=0.

Reset
REQ-032 rst=0 at an edge: wb_we, wb_addr, wb_data, hi, lo, md_busy and all muldiv state = 0.
REQ-033 Reset during md_busy aborts the operation; hi/lo stay 0 and in_ready = 1 on the first cycle after rst returns high.

Structure
REQ-034 Package exec_wb_pkg holds the op_sel encodings and the DIV-by-zero result constants.
REQ-035 One sub-module, muldiv_iter (start, signed, a, b, busy, done, hi, lo), parametrised by DATA_W; muxing, forwarding and interlock live in exec_wb_stage.

Verification
REQ-036 ALU, dest 5, alu_result 0x1234, then ALU rs_addr=5, rs_data=0 -> wb_data 0x1234 one edge later; opa_fwd 0x1234 in the second cycle.
REQ-037 MULT signed 0xFFFFFFFE x 3, then MFLO -> in_ready 0 for 32 cycles; MFLO then writes 0xFFFFFFFA; hi 0xFFFFFFFF.
REQ-038 DIV unsigned 7/0 -> lo 0xFFFFFFFF, hi 0x00000007; signed -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
REQ-039 ALU, dest 0, reg_we=1 -> wb_we 0; following rs_addr=0 gets rs_data, never forwarded.
REQ-040 ALU ops issued during md_busy -> accepted every cycle, correct wb_data; MFHI stalls until completion.
REQ-041 rst=0 at cycle 10 of a DIV -> md_busy 0, hi=lo=0, and a following MFHI writes 0.
